if_id_queue: RTL and testbench

Parametrised IF/ID instruction buffer that replaces the single-entry IF/ID pipeline register. It sits between the instruction-fetch stage and the decode stage. It absorbs fetched instructions into a DEPTH-entry FIFO while decode is stalled, and presents them to ID in order through a registered output stage. Flush discards all buffered and presented instructions in one cycle, for branch/jump redirect.

---
 rtl/if_id_queue.sv | 131 +++++++++++++
 tb/tb_if_id_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: DEPTH-entry FIFO behind a registered ID-facing output stage.
// Absorbs fetches while decode stalls; flush empties everything in one cycle.
module if_id_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         get_inst,
  input  logic [ADDR_WIDTH-1:0]        if_pc,
  input  logic [INST_WIDTH-1:0]        if_inst,
  input  logic                         if_idflush_i,
  input  logic [5:0]                   stall,
  output logic                         if_full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         id_valid_o,
  output logic [ADDR_WIDTH-1:0]        id_pc,
  output logic [INST_WIDTH-1:0]        id_inst
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("if_id_queue: DEPTH must be a power of two and >= 2");
  end

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  logic full, empty, advance, pop, bypass, push, mem_we;

  // Only stall[2] concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1:0]};

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // An empty output stage always refills, even while ID is stalled.
  assign advance = !stall[2] || !valid_q;
  assign pop     = advance && !empty;
  assign bypass  = advance && empty && get_inst;
  // Full blocks the push even when a same-cycle pop frees a slot.
  assign push    = get_inst && !full && !bypass;
  assign mem_we  = push && !if_idflush_i && !rst;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    inst_d   = inst_q;

    if (if_idflush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      pc_d     = '0;
      inst_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (advance) begin
        if (pop) begin
          valid_d = 1'b1;
          pc_d    = pc_mem_q[rd_ptr_q];
          inst_d  = inst_mem_q[rd_ptr_q];
        end else if (bypass) begin
          valid_d = 1'b1;
          pc_d    = if_pc;
          inst_d  = if_inst;
        end else begin
          valid_d = 1'b0;
          pc_d    = '0;
          inst_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
    end
  end

  // Storage needs no reset; the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
    end
  end

  assign if_full_o  = full;
  assign count_o    = count_q;
  assign id_valid_o = valid_q;
  assign id_pc      = pc_q;
  assign id_inst    = inst_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed vector table plus a randomised in-order stream check for if_id_queue.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        get_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_idflush_i;
  logic [5:0]  stall;
  logic        if_full_o;
  logic [2:0]  count_o;
  logic        id_valid_o;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_id_queue #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .get_inst    (get_inst),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_idflush_i(if_idflush_i),
    .stall       (stall),
    .if_full_o   (if_full_o),
    .count_o     (count_o),
    .id_valid_o  (id_valid_o),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  typedef struct {
    logic        r;
    logic        g;
    logic        f;
    logic        s;
    logic [31:0] pc;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        efull;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic add(input logic r, input logic g, input logic f, input logic s,
                     input logic [31:0] pc, input logic ev, input logic [31:0] epc,
                     input int ecnt, input logic efull);
    vec_t v;
    v.r = r; v.g = g; v.f = f; v.s = s; v.pc = pc;
    v.ev = ev; v.epc = epc; v.ecnt = 3'(ecnt); v.efull = efull;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic g, input logic f, input logic s,
                       input logic [31:0] pc);
    rst          = r;
    get_inst     = g;
    if_idflush_i = f;
    if_pc        = pc;
    if_inst      = inst_of(pc);
    stall        = {3'b000, s, 2'b01};
  endtask

  initial begin
    logic [31:0] expq[$];
    logic [31:0] next_pc;
    logic [31:0] epc, einst, exp_pc;
    logic        s, g, adv;
    int          pushed, got;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40);

    //  r  g  f  s  pc          ev  epc         cnt full
    add(1, 1, 0, 0, 32'h040,    0,  32'h000,    0,  0);  // reset, push ignored
    add(1, 1, 0, 0, 32'h040,    0,  32'h000,    0,  0);
    add(0, 1, 0, 0, 32'h000,    1,  32'h000,    0,  0);  // bypass stream
    add(0, 1, 0, 0, 32'h004,    1,  32'h004,    0,  0);
    add(0, 1, 0, 0, 32'h008,    1,  32'h008,    0,  0);
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);
    add(0, 1, 0, 1, 32'h100,    1,  32'h100,    0,  0);  // bubble refilled under stall
    add(0, 1, 0, 1, 32'h104,    1,  32'h100,    1,  0);
    add(0, 1, 0, 1, 32'h108,    1,  32'h100,    2,  0);
    add(0, 1, 0, 1, 32'h10C,    1,  32'h100,    3,  0);
    add(0, 1, 0, 1, 32'h110,    1,  32'h100,    4,  1);
    add(0, 1, 0, 1, 32'h114,    1,  32'h100,    4,  1);  // dropped
    add(0, 0, 0, 0, 32'h000,    1,  32'h104,    3,  0);  // stall release
    add(0, 0, 0, 0, 32'h000,    1,  32'h108,    2,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h10C,    1,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h110,    0,  0);
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);
    add(0, 1, 0, 1, 32'h180,    1,  32'h180,    0,  0);  // build count 2
    add(0, 1, 0, 1, 32'h184,    1,  32'h180,    1,  0);
    add(0, 1, 0, 1, 32'h188,    1,  32'h180,    2,  0);
    add(0, 1, 1, 1, 32'h200,    0,  32'h000,    0,  0);  // flush with push
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);
    add(0, 1, 0, 1, 32'h300,    1,  32'h300,    0,  0);  // build count 2
    add(0, 1, 0, 1, 32'h304,    1,  32'h300,    1,  0);
    add(0, 1, 0, 1, 32'h308,    1,  32'h300,    2,  0);
    add(0, 1, 0, 0, 32'h30C,    1,  32'h304,    2,  0);  // push+pop
    add(0, 1, 0, 0, 32'h310,    1,  32'h308,    2,  0);
    add(0, 1, 0, 0, 32'h314,    1,  32'h30C,    2,  0);
    add(0, 1, 0, 0, 32'h318,    1,  32'h310,    2,  0);
    add(0, 1, 0, 0, 32'h31C,    1,  32'h314,    2,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h318,    1,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h31C,    0,  0);
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);
    add(0, 1, 0, 1, 32'h400,    1,  32'h400,    0,  0);  // fill to full
    add(0, 1, 0, 1, 32'h404,    1,  32'h400,    1,  0);
    add(0, 1, 0, 1, 32'h408,    1,  32'h400,    2,  0);
    add(0, 1, 0, 1, 32'h40C,    1,  32'h400,    3,  0);
    add(0, 1, 0, 1, 32'h410,    1,  32'h400,    4,  1);
    add(0, 1, 0, 0, 32'h414,    1,  32'h404,    3,  0);  // pop while full: push refused
    add(0, 1, 0, 0, 32'h418,    1,  32'h408,    3,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h40C,    2,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h410,    1,  0);
    add(0, 0, 0, 0, 32'h000,    1,  32'h418,    0,  0);
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);
    add(0, 1, 0, 1, 32'h500,    1,  32'h500,    0,  0);  // reset beats flush
    add(0, 1, 0, 1, 32'h504,    1,  32'h500,    1,  0);
    add(1, 1, 1, 1, 32'h508,    0,  32'h000,    0,  0);
    add(0, 1, 0, 0, 32'h50C,    1,  32'h50C,    0,  0);
    add(0, 0, 0, 0, 32'h000,    0,  32'h000,    0,  0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].g, vecs[i].f, vecs[i].s, vecs[i].pc);
      @(posedge clk);
      #1;
      einst = vecs[i].ev ? inst_of(vecs[i].epc) : 32'h0;
      tests++;
      if (id_valid_o !== vecs[i].ev || id_pc !== vecs[i].epc || id_inst !== einst ||
          count_o !== vecs[i].ecnt || if_full_o !== vecs[i].efull) begin
        fails++;
        $display("FAIL vec%0d: got valid=%b pc=%h inst=%h cnt=%0d full=%b, want valid=%b pc=%h inst=%h cnt=%0d full=%b",
                 i, id_valid_o, id_pc, id_inst, count_o, if_full_o,
                 vecs[i].ev, vecs[i].epc, einst, vecs[i].ecnt, vecs[i].efull);
      end
    end

    // Random stall stream: 3*DEPTH pcs must reach ID once each, in order.
    next_pc = 32'h1000;
    pushed  = 0;
    got     = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = (pushed < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      g = (pushed < 12) && !if_full_o && ($urandom_range(0, 3) != 0);
      drive(1'b0, g, 1'b0, s, g ? next_pc : 32'h0);
      if (g) begin
        expq.push_back(next_pc);
        next_pc += 32'h4;
        pushed++;
      end
      adv = !s || !id_valid_o;
      @(posedge clk);
      #1;
      if (adv && id_valid_o) begin
        got++;
        tests++;
        exp_pc = (expq.size() != 0) ? expq.pop_front() : 32'hFFFF_FFFF;
        if (id_pc !== exp_pc || id_inst !== inst_of(exp_pc)) begin
          fails++;
          $display("FAIL stream%0d: got pc=%h inst=%h, want pc=%h inst=%h",
                   got, id_pc, id_inst, exp_pc, inst_of(exp_pc));
        end
      end
      if (pushed == 12 && expq.size() == 0 && !id_valid_o) break;
      if (pushed == 12 && expq.size() == 0 && adv) begin
        epc = 32'h0;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    tests++;
    if (got != 12 || expq.size() != 0 || id_valid_o !== 1'b0 || count_o !== 3'd0) begin
      fails++;
      $display("FAIL stream_end: got received=%0d left=%0d valid=%b cnt=%0d, want 12 0 0 0",
               got, expq.size(), id_valid_o, count_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
